dmem_ctrl: RTL and testbench

//  Parametrised RV32 data memory: word array with byte-lane stores (SB/SH/SW) and sign/zero-extending loads.

---
 rtl/dmem_pkg.sv | 48 ++++
 rtl/dmem_align.sv | 43 ++++
 rtl/dmem_ctrl.sv | 112 +++++++++++
 tb/tb_dmem_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32 data memory controller.
//   F3_*          : RV32 load/store funct3 encodings
//   NUM_LANES     : byte lanes per 32-bit word
//   state_t       : controller state (INIT clear sweep, READY serving requests)
//   rsp_ctl_t     : per-response control captured at acceptance
//   extend_load   : lane select plus sign/zero extension of a read word
//   f3_illegal    : funct3 legality for loads/stores
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int NUM_LANES = 4;

  typedef enum logic {INIT, READY} state_t;

  typedef struct packed {
    logic       ld;      // response carries load data
    logic [1:0] lane;
    logic [2:0] funct3;
  } rsp_ctl_t;

  function automatic logic [31:0] extend_load(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  funct3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    extend_load = {{24{b[7]}}, b};
      F3_BU:   extend_load = {24'h0, b};
      F3_H:    extend_load = {{16{h[15]}}, h};
      F3_HU:   extend_load = {16'h0, h};
      default: extend_load = word;
    endcase
  endfunction

  // Stores only know B/H/W; loads additionally accept BU/HU.
  function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
    if (we) f3_illegal = (funct3 > F3_W);
    else    f3_illegal = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Store alignment helper (combinational).
//   size     in  2   funct3[1:0]: 0 byte, 1 half, 2 word
//   lane     in  2   byte address bits [1:0]
//   wdata    in  32  LSB-aligned store data
//   be       out 4   byte enables
//   wword    out 32  store data replicated onto its lanes
//   misalign out 1   half on odd byte or word off a word boundary
module dmem_align
  import dmem_pkg::*;
(
  input  logic [1:0]           size,
  input  logic [1:0]           lane,
  input  logic [31:0]          wdata,
  output logic [NUM_LANES-1:0] be,
  output logic [31:0]          wword,
  output logic                 misalign
);

  // Replicating the data onto every lane lets be alone pick the target lane,
  // and drops the unused upper bits of wdata for free.
  always_comb begin
    be       = '0;
    wword    = wdata;
    misalign = 1'b0;
    case (size)
      2'd0: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
      end
      2'd1: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        misalign = lane[0];
      end
      2'd2: begin
        be       = 4'b1111;
        misalign = (lane != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// RV32 data memory: byte-lane stores, extending loads, 1-cycle registered
// responses, fault detection and an optional clear sweep after reset.
//   clock, resetn (sync, active low)
//   req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata : request port
//   rsp_valid/rsp_rdata/rsp_err                               : response port
//   init_done : clear sweep finished (sticky until reset)
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter bit RESET_CLEAR = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t                  state, state_d;
  logic [IDX_W-1:0]        cnt, cnt_d, idx;
  logic [NUM_LANES-1:0]    be;
  logic [31:0]             wword;
  logic [NUM_LANES-1:0][7:0] rd_word;
  logic                    misalign, oor, err, accept, wr_en, sweep;
  rsp_ctl_t                ctl_q;

  assign req_ready = resetn && (state == READY);
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[IDX_W+1:2];
  assign oor       = (req_addr >> (IDX_W + 2)) != '0;
  assign err       = oor || misalign || f3_illegal(req_we, req_funct3);
  assign wr_en     = accept && req_we && !err;
  assign sweep     = resetn && (state == INIT);

  dmem_align u_align (
    .size     (req_funct3[1:0]),
    .lane     (req_addr[1:0]),
    .wdata    (req_wdata),
    .be       (be),
    .wword    (wword),
    .misalign (misalign)
  );

  // One bank per byte lane so each byte enable is a plain per-bank write.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_bank
    logic [7:0] bank [0:DEPTH-1];
    logic [7:0] rd_q;
    always_ff @(posedge clock) begin
      if (sweep)                bank[cnt] <= 8'h00;
      else if (wr_en && be[l])  bank[idx] <= wword[8*l +: 8];
      if (accept && !req_we)    rd_q <= bank[idx];
    end
    assign rd_word[l] = rd_q;
  end

  // FSM: INIT clears one word per cycle, then READY forever.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= RESET_CLEAR ? INIT : READY;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      init_done <= (state_d == READY);
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      INIT: begin
        cnt_d = cnt + 1'b1;
        if (cnt == IDX_W'(DEPTH - 1)) state_d = READY;
      end
      default: ;
    endcase
  end

  // Response registers; the reset branch drops anything in flight.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      ctl_q     <= '0;
    end else begin
      rsp_valid <= accept;
      rsp_err   <= accept && err;
      ctl_q.ld  <= accept && !req_we && !err;
      if (accept) begin
        ctl_q.lane   <= req_addr[1:0];
        ctl_q.funct3 <= req_funct3;
      end
    end
  end

  // Lane select/extension after the synchronous read; zero unless a good load.
  assign rsp_rdata = ctl_q.ld ? extend_load(rd_word, ctl_q.lane, ctl_q.funct3) : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        init_done;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dmem_ctrl #(.ADDR_W(32), .DEPTH(256), .RESET_CLEAR(1'b1)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_done  (init_done)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata,
                              input string name);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Present one request for one edge; sample the response 1 time unit later.
  task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, output logic v, output logic e,
                      output logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clock); #1;
    v = rsp_valid; e = rsp_err; d = rsp_rdata;
    req_valid = 1'b0;
  endtask

  // Count cycles after reset release until req_ready; bounded.
  task automatic wait_ready(output int n, output logic early_done);
    n = 0;
    early_done = 1'b0;
    while (!req_ready && n < 400) begin
      if (init_done) early_done = 1'b1;
      @(posedge clock); #1;
      n++;
    end
  endtask

  initial begin
    logic        v, e;
    logic [31:0] d;
    int          n;
    logic        early;

    // stores: we=1; loads: we=0
    add(0, F3_W,  32'h3FC, 32'h0,        0, 32'h00000000, "lw_3fc_cleared");
    add(1, F3_W,  32'h010, 32'hDEADBEEF, 0, 32'h00000000, "sw_10");
    add(0, F3_B,  32'h013, 32'h0,        0, 32'hFFFFFFDE, "lb_13");
    add(0, F3_BU, 32'h012, 32'h0,        0, 32'h000000AD, "lbu_12");
    add(0, F3_H,  32'h010, 32'h0,        0, 32'hFFFFBEEF, "lh_10");
    add(0, F3_HU, 32'h012, 32'h0,        0, 32'h0000DEAD, "lhu_12");
    add(1, F3_B,  32'h011, 32'h12345655, 0, 32'h00000000, "sb_11");
    add(0, F3_W,  32'h010, 32'h0,        0, 32'hDEAD55EF, "lw_10_after_sb");
    add(1, F3_H,  32'h012, 32'h00007F01, 0, 32'h00000000, "sh_12");
    add(0, F3_W,  32'h010, 32'h0,        0, 32'h7F0155EF, "lw_10_after_sh");
    add(0, F3_B,  32'h011, 32'h0,        0, 32'h00000055, "lb_11_pos");
    add(0, F3_H,  32'h012, 32'h0,        0, 32'h00007F01, "lh_12_pos");
    add(0, F3_H,  32'h011, 32'h0,        1, 32'h00000000, "lh_11_misalign");
    add(1, F3_W,  32'h012, 32'hFFFFFFFF, 1, 32'h00000000, "sw_12_misalign");
    add(1, F3_H,  32'h013, 32'hFFFFFFFF, 1, 32'h00000000, "sh_13_misalign");
    add(1, 3'd3,  32'h010, 32'hFFFFFFFF, 1, 32'h00000000, "store_f3_3");
    add(1, 3'd4,  32'h010, 32'hFFFFFFFF, 1, 32'h00000000, "store_f3_4");
    add(0, F3_W,  32'h010, 32'h0,        0, 32'h7F0155EF, "lw_10_unchanged");
    add(0, F3_W,  32'h400, 32'h0,        1, 32'h00000000, "lw_400_oor");
    add(0, F3_W,  32'h80000010, 32'h0,   1, 32'h00000000, "lw_high_oor");
    add(0, 3'd3,  32'h010, 32'h0,        1, 32'h00000000, "load_f3_3");
    add(0, 3'd6,  32'h010, 32'h0,        1, 32'h00000000, "load_f3_6");
    add(0, 3'd7,  32'h010, 32'h0,        1, 32'h00000000, "load_f3_7");
    add(1, F3_W,  32'h014, 32'h80000001, 0, 32'h00000000, "sw_14");
    add(0, F3_HU, 32'h016, 32'h0,        0, 32'h00008000, "lhu_16");
    add(0, F3_H,  32'h016, 32'h0,        0, 32'hFFFF8000, "lh_16");
    add(0, F3_B,  32'h014, 32'h0,        0, 32'h00000001, "lb_14");
    add(0, F3_BU, 32'h017, 32'h0,        0, 32'h00000080, "lbu_17");
    add(0, F3_B,  32'h017, 32'h0,        0, 32'hFFFFFF80, "lb_17");
    add(1, F3_B,  32'h015, 32'hFFFFFF7E, 0, 32'h00000000, "sb_15_upper_ignored");
    add(0, F3_W,  32'h014, 32'h0,        0, 32'h80007E01, "lw_14");
    add(1, F3_W,  32'h3FC, 32'h01234567, 0, 32'h00000000, "sw_last_word");
    add(0, F3_W,  32'h3FC, 32'h0,        0, 32'h01234567, "lw_last_word");
    add(1, F3_W,  32'h400, 32'hFFFFFFFF, 1, 32'h00000000, "sw_400_oor");
    add(0, F3_W,  32'h000, 32'h0,        0, 32'h00000000, "lw_0_no_alias");
    add(1, F3_W,  32'h020, 32'hA5A5A5A5, 0, 32'h00000000, "b2b_sw_20");
    add(0, F3_W,  32'h020, 32'h0,        0, 32'hA5A5A5A5, "b2b_lw_20");

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err",   32'(rsp_err), 32'd0);
    chk("reset_init_done", 32'(init_done), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    resetn = 1'b1;

    // Clear sweep takes exactly DEPTH cycles
    wait_ready(n, early);
    chk("sweep_cycles", 32'(n), 32'd256);
    chk("sweep_init_done_early", 32'(early), 32'd0);
    chk("sweep_init_done", 32'(init_done), 32'd1);

    // Vectors run back to back, one per cycle
    foreach (vecs[i]) begin
      chk($sformatf("v%0d_%s_ready", i, vecs[i].name), 32'(req_ready), 32'd1);
      xact(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, v, e, d);
      chk($sformatf("v%0d_%s_valid", i, vecs[i].name), 32'(v), 32'd1);
      chk($sformatf("v%0d_%s_err",   i, vecs[i].name), 32'(e), 32'(vecs[i].err));
      chk($sformatf("v%0d_%s_rdata", i, vecs[i].name), d, vecs[i].rdata);
    end

    // Idle cycle: no response
    @(posedge clock); #1;
    chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle_rsp_rdata", rsp_rdata, 32'h0);

    // Accepted load followed by reset: response is dropped
    xact(0, F3_W, 32'h020, 32'h0, v, e, d);
    chk("pre_reset_lw_rdata", d, 32'hA5A5A5A5);
    resetn = 1'b0;
    @(posedge clock); #1;
    chk("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midreset_rsp_rdata", rsp_rdata, 32'h0);
    chk("midreset_init_done", 32'(init_done), 32'd0);

    // Request presented while reset is low is never accepted
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h020;
    #1;
    chk("inreset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    chk("inreset_rsp_valid", 32'(rsp_valid), 32'd0);
    req_valid = 1'b0;
    resetn = 1'b1;
    #1;
    chk("post_reset_req_ready", 32'(req_ready), 32'd0);

    // Sweep restarts from word 0 and clears everything again
    wait_ready(n, early);
    chk("resweep_cycles", 32'(n), 32'd256);
    chk("resweep_init_done", 32'(init_done), 32'd1);
    xact(0, F3_W, 32'h020, 32'h0, v, e, d);
    chk("resweep_lw_20", d, 32'h0);
    xact(0, F3_W, 32'h3FC, 32'h0, v, e, d);
    chk("resweep_lw_3fc", d, 32'h0);
    chk("resweep_lw_3fc_valid", 32'(v), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
